// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then shifts one byte
// out on device-generated clock edges and checks the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 240,
    parameter int TIMEOUT_CYCLES = 30000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_active,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, WAIT_IDLE} state_t;

    state_t           state, state_next;
    logic             clk_meta, clk_sync, clk_prev;
    logic             data_meta, data_sync;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             clk_oe_d, data_oe_d, done_d, error_d;
    logic             clk_fall, timeout;

    assign clk_fall  = clk_prev & ~clk_sync;
    assign timeout   = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign tx_ready  = (state == IDLE);
    assign tx_active = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments only; the async reset
    // releases both lines immediately, without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            clk_meta    <= 1'b1;
            clk_sync    <= 1'b1;
            clk_prev    <= 1'b1;
            data_meta   <= 1'b1;
            data_sync   <= 1'b1;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            bit_cnt_q   <= '0;
            inh_cnt_q   <= '0;
            to_cnt_q    <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
        end else begin
            state       <= state_next;
            clk_meta    <= ps2_clk_in;
            clk_sync    <= clk_meta;
            clk_prev    <= clk_sync;
            data_meta   <= ps2_data_in;
            data_sync   <= data_meta;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            bit_cnt_q   <= bit_cnt_d;
            inh_cnt_q   <= inh_cnt_d;
            to_cnt_q    <= to_cnt_d;
            ps2_clk_oe  <= clk_oe_d;
            ps2_data_oe <= data_oe_d;
            tx_done     <= done_d;
            tx_error    <= error_d;
        end
    end

    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_next = state;
        shift_d    = shift_q;
        parity_d   = parity_q;
        bit_cnt_d  = bit_cnt_q;
        inh_cnt_d  = '0;
        to_cnt_d   = '0;
        data_oe_d  = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;

        case (state)
            IDLE: begin
                if (tx_valid) begin
                    shift_d    = tx_data;
                    parity_d   = ~^tx_data;
                    state_next = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                    state_next = REQ;
                    data_oe_d  = 1'b1;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            REQ, SEND, WAIT_IDLE: begin
                // Timeout wins over any line event in the same cycle.
                if (timeout) begin
                    error_d    = 1'b1;
                    state_next = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (state == REQ) begin
                        bit_cnt_d  = '0;
                        data_oe_d  = 1'b1;
                        state_next = SEND;
                    end else if (state == SEND) begin
                        data_oe_d = ps2_data_oe;
                        if (clk_fall) begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            if (bit_cnt_q < 4'd8) begin
                                data_oe_d = ~shift_q[0];
                                shift_d   = {1'b0, shift_q[7:1]};
                            end else if (bit_cnt_q == 4'd8) begin
                                data_oe_d = ~parity_q;
                            end else if (bit_cnt_q == 4'd9) begin
                                data_oe_d = 1'b0;
                            end else begin
                                data_oe_d = 1'b0;
                                if (data_sync) begin
                                    error_d    = 1'b1;
                                    state_next = IDLE;
                                end else begin
                                    state_next = WAIT_IDLE;
                                end
                            end
                        end
                    end else if (clk_sync && data_sync) begin
                        done_d     = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        clk_oe_d = (state_next == INHIBIT);
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends single command bytes to a keyboard or mouse, e.g. 0xF4 "enable reporting" to the mouse or 0xED + LED mask to the keyboard.
- Drives the open-drain PS/2 clock and data lines through active-high pull-low enables.
- Sits beside the existing PS/2 receiver on the same clock and lines. It raises tx_active so the receiver path can ignore the transfer's edges.

Parameters:
- INHIBIT_CYCLES, 240: clk cycles the host holds PS/2 clock low before the request-to-send (120 us at 2 MHz).
- TIMEOUT_CYCLES, 30000: maximum clk cycles from clock release until the ACK and idle lines are seen (15 ms at 2 MHz).

Ports:
- clk  in  1  system clock, 2 MHz nominal
- reset  in  1  asynchronous, active-high reset
- tx_data  in  8  byte to send
- tx_valid  in  1  request; accepted when tx_valid && tx_ready
- tx_ready  out  1  high only in IDLE
- ps2_clk_in  in  1  raw PS/2 clock line level
- ps2_data_in  in  1  raw PS/2 data line level
- ps2_clk_oe  out  1  1 = pull PS/2 clock low
- ps2_data_oe  out  1  1 = pull PS/2 data low
- tx_active  out  1  high from accept until return to IDLE
- tx_done  out  1  one-cycle pulse: byte ACKed by the device
- tx_error  out  1  one-cycle pulse: NACK or timeout

Behaviour:
- Input synchronisation: ps2_clk_in and ps2_data_in each pass through a 2-FF synchroniser. A falling edge is sync_clk == 0 with previous == 1. All line sampling uses the synchronised values.
- Reset: asynchronous, active-high. While reset is asserted and on release: state = IDLE, ps2_clk_oe = 0, ps2_data_oe = 0, tx_ready = 1, tx_active = 0, tx_done = 0, tx_error = 0, all counters = 0. Reset during any transfer releases both lines immediately, with no clock edge needed.
- Accept: in IDLE, tx_valid && tx_ready latches tx_data into a shift register and computes parity = ~^tx_data (odd parity). The block then moves to INHIBIT on the next cycle, with tx_ready = 0 and tx_active = 1. tx_valid is ignored outside IDLE.
- INHIBIT: ps2_clk_oe = 1, ps2_data_oe = 0 for exactly INHIBIT_CYCLES cycles.
- REQ (one cycle):
  - ps2_data_oe = 1 (start bit 0), ps2_clk_oe = 0.
  - Clear bit counter and timeout counter, then go to SEND.
- SEND: the device generates the clock. The host updates data on each synchronised falling edge; the device samples on rising edges. Falling edge n (n = 1..11):
  - n = 1..8: ps2_data_oe = ~tx_data[n-1], LSB first.
  - n = 9: ps2_data_oe = ~parity.
  - n = 10: ps2_data_oe = 0 (stop bit, line released).
  - n = 11: sample sync data. 0 = ACK, go to WAIT_IDLE; 1 = NACK, pulse tx_error and go to IDLE.
- WAIT_IDLE: wait until sync clock == 1 and sync data == 1, then pulse tx_done and go to IDLE.
- Timeout:
  - The counter runs in REQ, SEND and WAIT_IDLE.
  - On reaching TIMEOUT_CYCLES: pulse tx_error, force both oe to 0, go to IDLE.
  - Timeout takes priority over a falling edge seen in the same cycle.
- Outputs: tx_done and tx_error never assert together. Both are registered. tx_ready rises the same cycle the state enters IDLE.
- Line ownership: ps2_clk_oe is asserted only in INHIBIT. ps2_data_oe is asserted only in REQ and SEND. Both are 0 in IDLE and WAIT_IDLE.
- Back-to-back: tx_valid held high re-accepts on the first IDLE cycle after done or error. There is no minimum idle gap.

Test Plan:
- Send 0xF4 with a device model clocking at 12.5 kHz and ACKing:
  - ps2_clk_oe = 1 for exactly 240 cycles, then data is held low.
  - Sampled bits are 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - One tx_done pulse, no tx_error, tx_ready back to 1.
- Send 0xED then 0x07 back-to-back with tx_valid held high:
  - 0xED yields parity 1; 0x07 yields parity 0.
  - Two tx_done pulses, and tx_active drops between them for at least one cycle.
- NACK: device leaves data high on the 11th clock -> one tx_error pulse, no tx_done, both oe = 0, state IDLE.
- Timeout: device never clocks after REQ -> tx_error pulses exactly TIMEOUT_CYCLES cycles after REQ, and ps2_data_oe drops to 0 in that same cycle.
- Reset mid-transfer: assert reset after the 5th falling edge -> ps2_data_oe and ps2_clk_oe are 0 asynchronously, before the next clk edge. tx_ready = 1 after release, and a subsequent 0xF4 transfer succeeds.
- tx_valid pulsed with 0xAA during SEND of 0x55 -> ignored. Only 0x55 bits appear on the line and exactly one tx_done pulses.
